adder_rr_scheduler: RTL and testbench
=====================================

// Module: adder_rr_scheduler
// PURPOSE
//  Round-robin scheduler that time-shares one registered 8-bit adder (existing module `adder`,
//  instantiated here) among NREQ requesters. Each requester issues an operand pair over a
//  valid/ready handshake; the result returns on a single shared response channel tagged with
//  the requester index. Sits between client blocks and the adder datapath; one op in flight.
// PARAMETERS
//  NREQ   4                  number of requesters (>=2)
//  WIDTH  8                  operand width; fixed by `adder`, do not override
//  IDW    $clog2(NREQ)       response tag width
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NREQ        per-requester request valid
//  req_ready  out  NREQ        per-requester accept (one-hot or zero)
//  req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand B, same packing
//  rsp_valid  out  1           result valid
//  rsp_ready  in   1           consumer accepts result
//  rsp_id     out  IDW         index of requester that owns the result
//  rsp_sum    out  WIDTH       a+b mod 2^WIDTH
//  rsp_cout   out  1           carry out of a+b
//  busy       out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, ptr=0, op regs=0. While rst=1: req_ready=0, rsp_valid=0,
//   rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0. Reset mid-op abandons the op; its result is never issued.
//  FSM IDLE -> CALC -> RESP -> IDLE.
//   IDLE: if |req_valid, grant g = first i with req_valid[i] searching ptr, ptr+1, ... (mod NREQ).
//     req_ready[g]=1 combinationally this cycle only; at posedge latch op_a/op_b from g, gid=g, -> CALC.
//     req_ready is 0 in every other state; no request is accepted while busy.
//   CALC: op regs drive adder a/b; adder registers sum/cout at this posedge; -> RESP.
//   RESP: rsp_valid=1; rsp_id=gid; rsp_sum/rsp_cout = adder outputs (stable, op regs held).
//     On rsp_valid&rsp_ready: ptr=(gid+1) mod NREQ, -> IDLE. Otherwise hold all outputs unchanged.
//  rsp_sum/rsp_cout/rsp_id forced to 0 outside RESP.
//  Latency: handshake in cycle N -> rsp_valid high from cycle N+2. Peak throughput 1 op / 3 cycles
//   (rsp_ready held high).
//  Requester deasserting req_valid before grant is legal; it is simply skipped. Operands not
//   re-sampled after the grant cycle.
//  Fairness: a requester holding req_valid is granted within NREQ ops.
//  Arithmetic: {rsp_cout,rsp_sum} = req_a_g + req_b_g, 9-bit unsigned; no saturation.
// STRUCTURE
//  Shared package: WIDTH constant, FSM state encoding (IDLE=0, CALC=1, RESP=2).
//  Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant and its index;
//   purely combinational. The FSM, op regs, ptr and `adder` instance live in the top.
// TESTING
//  1 Only req0: a=15,b=10 handshake cycle N -> rsp_valid at N+2, id=0, sum=25, cout=0.
//  2 Sequential ops on req1: 200+100 -> sum=44,cout=1; 255+1 -> 0,1; 127+127 -> 254,0.
//  3 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; one accept per 3 cycles.
//  4 ptr=2, req1 and req2 valid -> req2 granted first, then req1.
//  5 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1; accept on 6th.
//  6 rst pulsed during CALC -> next cycle all outputs 0, state IDLE; after release lone req3
//    (a=1,b=2) granted, result sum=3 id=3; aborted op never appears.

Source files
------------

// File: rtl/adder_rr_scheduler_pkg.sv
// adder_rr_scheduler_pkg: shared operand width and scheduler FSM encoding
package adder_rr_scheduler_pkg;
    localparam int WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;
endpackage

// File: rtl/adder.sv
// adder: registered WIDTH-bit adder with carry out
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    always_ff @(posedge clk) {cout, sum} <= {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    logic [IDW-1:0] idx;
    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                grant     = NREQ'(1) << idx;
                grant_idx = idx;
            end
        end
    end
endmodule

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of one registered adder among NREQ requesters,
// one op in flight, result tagged with the owning requester on a shared response channel
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);
    state_e           state_q;
    logic [IDW-1:0]   ptr_q, gid_q, ptr_d, grant_idx;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] op_a_q, op_b_q, sel_a, sel_b, sum;
    logic             cout;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    adder #(.WIDTH(WIDTH)) u_adder (
        .clk  (clk),
        .a    (op_a_q),
        .b    (op_b_q),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_d = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req_valid) begin
                    op_a_q  <= sel_a;
                    op_b_q  <= sel_b;
                    gid_q   <= grant_idx;
                    state_q <= CALC;
                end
                CALC: state_q <= RESP;
                RESP: if (rsp_ready) begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Op regs stay frozen through RESP, so the adder output is stable while stalled.
    assign req_ready = (!rst && state_q == IDLE) ? grant : '0;
    assign rsp_valid = !rst && state_q == RESP;
    assign rsp_id    = rsp_valid ? gid_q : '0;
    assign rsp_sum   = rsp_valid ? sum : '0;
    assign rsp_cout  = rsp_valid && cout;
    assign busy      = !rst && state_q != IDLE;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed vectors, expected responses queued at grant and
// checked by an independent response monitor
module tb_adder_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;
    logic        busy;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [10:0] sb[$];

    adder_rr_scheduler #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready[id];
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL grant_timeout: req%0d got no ready, expected ready within 20 cycles", id);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            done = !busy;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy stuck at 1, expected 0 within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
        bit ok;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        wait_grant(id, ok);
        if (ok) sb.push_back({2'(id), ec, es});
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        wait_idle();
    endtask

    // Response monitor: every accepted response must match the oldest queued expectation.
    initial forever begin
        @(negedge clk);
        if (rsp_valid === 1'b1 && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d sum=%0d cout=%0d expected no response",
                         rsp_id, rsp_sum, rsp_cout);
            end else begin
                chk("rsp_id_cout_sum", {21'b0, rsp_id, rsp_cout, rsp_sum}, {21'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        bit ok;
        int k, last;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", {rsp_id, rsp_cout, rsp_sum}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        // Latency: handshake in N, response visible in N+2
        req_a[7:0] = 8'd15;
        req_b[7:0] = 8'd10;
        req_valid  = 4'b0001;
        wait_grant(0, ok);
        if (ok) sb.push_back({2'd0, 1'b0, 8'd25});
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("lat_n1_rsp_valid", rsp_valid, 0);
        chk("lat_n1_busy", busy, 1);
        @(negedge clk);
        chk("lat_n2_rsp_valid", rsp_valid, 1);
        wait_idle();
        do_op(1, 8'd200, 8'd100, 8'd44, 1'b1);
        do_op(1, 8'd255, 8'd1, 8'd0, 1'b1);
        do_op(1, 8'd127, 8'd127, 8'd254, 1'b0);
        // ptr now 2: req2 wins over req1
        req_a[15:8]  = 8'd3;
        req_b[15:8]  = 8'd4;
        req_a[23:16] = 8'd8;
        req_b[23:16] = 8'd9;
        req_valid    = 4'b0110;
        @(negedge clk);
        chk("ptr2_first_grant", req_ready, 4'b0100);
        sb.push_back({2'd2, 1'b0, 8'd17});
        @(posedge clk);
        #1 req_valid = 4'b0010;
        wait_grant(1, ok);
        if (ok) begin
            chk("ptr2_second_grant", req_ready, 4'b0010);
            sb.push_back({2'd1, 1'b0, 8'd7});
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        // Reset to ptr=0, then all four held valid
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(10 * (i + 1));
            req_b[i*8 +: 8] = 8'(i + 1);
        end
        req_valid = 4'hF;
        k = 0;
        last = 0;
        for (int t = 0; t < 40 && k < 5; t++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                chk("rr_grant", req_ready, 1 << (k % 4));
                if (k > 0) chk("rr_gap", cyc - last, 3);
                last = cyc;
                sb.push_back({2'(k % 4), 1'b0, 8'(11 * (k % 4 + 1))});
                k++;
                if (k == 5) begin
                    @(posedge clk);
                    #1 req_valid = '0;
                end
            end
        end
        chk("rr_grant_count", k, 5);
        wait_idle();
        // Response stalled 5 cycles with another requester waiting
        rsp_ready  = 1'b0;
        req_a[7:0] = 8'd100;
        req_b[7:0] = 8'd50;
        req_valid  = 4'b0001;
        wait_grant(0, ok);
        if (ok) sb.push_back({2'd0, 1'b0, 8'd150});
        @(posedge clk);
        #1;
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd6;
        req_valid    = 4'b0100;
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        chk("stall_rsp_seen", ok, 1);
        for (int s = 0; s < 5; s++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_data", {rsp_id, rsp_cout, rsp_sum}, {2'd0, 1'b0, 8'd150});
            chk("stall_req_ready", req_ready, 0);
            chk("stall_busy", busy, 1);
            @(posedge clk);
            #1;
            if (s < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_grant(2, ok);
        if (ok) sb.push_back({2'd2, 1'b0, 8'd11});
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        // Reset during CALC abandons the op
        req_a[15:8] = 8'd50;
        req_b[15:8] = 8'd60;
        req_valid   = 4'b0010;
        wait_grant(1, ok);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_rst_busy", busy, 0);
        chk("abort_in_rst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_after_busy", busy, 0);
        chk("abort_after_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
        @(posedge clk);
        #1;
        do_op(3, 8'd1, 8'd2, 8'd3, 1'b0);
        repeat (5) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
